// File: rtl/div_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the sequential restoring divider.
// Provides the FSM state encoding, the default operand width and a
// constant-evaluable ceil(log2) used to size the step counter.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_ripple_sub.sv
`timescale 1ns/1ps
// Ripple subtractor a - b built from a chain of full-adder cells:
// b is inverted and the carry-in is tied to 1 (two's complement add).
// Ports:
//   a, b    N-bit unsigned operands
//   diff    N-bit difference (modulo 2^N)
//   borrow  1 when a < b (inverse of the final carry-out)
module ripple_sub #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   carry;
  logic [N-1:0] b_n;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  // One full-adder cell per bit
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
`timescale 1ns/1ps
// Bit-serial unsigned restoring divider, one quotient bit per clock.
// Start/done slave: a start seen while not busy captures the operands;
// WIDTH RUN cycles later a one-cycle done pulse flags valid results,
// which are then held until the next accepted start. A zero divisor
// skips RUN and reports quotient=all ones, remainder=dividend.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only when busy=0
//   dividend      WIDTH-bit unsigned numerator
//   divisor       WIDTH-bit unsigned denominator
//   busy          high while the iteration is running
//   done          one-cycle completion pulse
//   quotient      WIDTH-bit result quotient
//   remainder     WIDTH-bit result remainder
//   div_by_zero   set with done when the divisor was zero
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned CW = (clog2(WIDTH) == 0) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [RW-1:0]    r, r_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] d, d_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic             div_by_zero_nxt;

  logic             accept;
  logic             divisor_zero;
  logic [RW-1:0]    shifted;
  logic [RW-1:0]    trial;
  logic             borrow;
  logic [RW-1:0]    r_step;
  logic [WIDTH-1:0] q_step;

  assign divisor_zero = (divisor == '0);

  // Partial remainder shifted left with the next dividend bit. The top
  // bit of R is always 0 after a step (R < D), so dropping it is exact.
  assign shifted = RW'({r, q[WIDTH-1]});

  ripple_sub #(
    .N(RW)
  ) u_sub (
    .a      (shifted),
    .b      (RW'({1'b0, d})),
    .diff   (trial),
    .borrow (borrow)
  );

  // Restoring step: keep the trial difference only when it did not borrow
  always_comb begin
    r_step = borrow ? shifted : trial;
    q_step = {q[WIDTH-2:0], ~borrow};
  end

  // Next-state logic; IDLE and DONE share the same start rules
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = divisor_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values: operand capture, iteration, result load
  always_comb begin
    r_nxt           = r;
    q_nxt           = q;
    d_nxt           = d;
    cnt_nxt         = cnt;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;
    if (accept) begin
      r_nxt           = '0;
      q_nxt           = dividend;
      d_nxt           = divisor;
      cnt_nxt         = CNT_LAST;
      div_by_zero_nxt = 1'b0;
      if (divisor_zero) begin
        quotient_nxt    = '1;
        remainder_nxt   = dividend;
        div_by_zero_nxt = 1'b1;
      end
    end else if (state == S_RUN) begin
      r_nxt = r_step;
      q_nxt = q_step;
      if (cnt != '0) begin
        cnt_nxt = cnt - CW'(1);
      end else begin
        // Final step: results land together with the DONE transition
        quotient_nxt  = q_step;
        remainder_nxt = WIDTH'(r_step);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers; busy/done track the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r           <= r_nxt;
      q           <= q_nxt;
      d           <= d_nxt;
      cnt         <= cnt_nxt;
      busy        <= (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
`timescale 1ns/1ps
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed
// vector table, hand-written handshake/reset sequences and random
// operands compared against plain integer division.
module tb_seq_restoring_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           edges;
    int           busy_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain unsigned division, divide-by-zero convention
  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (dv == 0) begin
      q = '1;
      r = dd;
      z = 1'b1;
    end else begin
      q = dd / dv;
      r = dd % dv;
      z = 1'b0;
    end
  endfunction

  // Issue one division and wait for done. Edges are counted from the
  // accepting edge (which counts as 1). At edge index poke_at a second
  // start with other operands is pulsed, which must be ignored.
  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input int poke_at,
                        output int edges, output int busy_cyc,
                        output int overlap, output int got_done);
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    edges    = 0;
    busy_cyc = 0;
    overlap  = 0;
    got_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cyc++;
      if (busy && done) overlap++;
      if (done) begin
        start    = 1'b0;
        got_done = 1;
        break;
      end
      if (edges == poke_at) begin
        start    = 1'b1;
        dividend = 8'd60;
        divisor  = 8'd8;
      end else begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
  endtask

  initial begin
    int e, bc, ov, gd, done_seen;
    logic [W-1:0] mq, mr, dd, dv;
    logic mz;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 8};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 8};
    vecs[4] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1, 0};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9, 8};
    vecs[6] = '{8'd60,  8'd8,   8'd7,   8'd4,   1'b0, 9, 8};
    vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9, 8};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      do_div(vecs[i].dd, vecs[i].dv, -1, e, bc, ov, gd);
      chk($sformatf("vec%0d_done", i), gd, 1);
      chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].z);
      chk($sformatf("vec%0d_latency", i), e, vecs[i].edges);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].busy_cyc);
      chk($sformatf("vec%0d_busy_done_overlap", i), ov, 0);
    end

    // start pulsed mid-RUN with other operands is ignored
    do_div(8'd100, 8'd7, 3, e, bc, ov, gd);
    chk("midrun_done", gd, 1);
    chk("midrun_quotient", quotient, 14);
    chk("midrun_remainder", remainder, 2);
    chk("midrun_latency", e, 9);

    // start held high through DONE: back-to-back acceptance
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    e  = 0;
    gd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (done) begin
        gd       = 1;
        dividend = 8'd60;
        divisor  = 8'd8;
        break;
      end
    end
    chk("b2b_first_done", gd, 1);
    chk("b2b_first_quotient", quotient, 14);
    chk("b2b_first_remainder", remainder, 2);
    chk("b2b_first_latency", e, 9);
    e  = 0;
    gd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (e == 1) begin
        chk("b2b_busy_rise", busy, 1);
        chk("b2b_done_single_cycle", done, 0);
        start = 1'b0;
      end
      if (done) begin
        gd = 1;
        break;
      end
    end
    chk("b2b_second_done", gd, 1);
    chk("b2b_second_quotient", quotient, 7);
    chk("b2b_second_remainder", remainder, 4);
    chk("b2b_second_latency", e, 9);

    // Asynchronous reset between edges clears held results at once
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Abort a running division with reset
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i == 2) rst = 1'b0;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_busy", busy, 0);
    do_div(8'd9, 8'd3, -1, e, bc, ov, gd);
    chk("after_abort_done", gd, 1);
    chk("after_abort_quotient", quotient, 3);
    chk("after_abort_remainder", remainder, 0);

    // Random operands against the reference model
    for (int n = 0; n < 300; n++) begin
      dd = W'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(dd, dv, mq, mr, mz);
      do_div(dd, dv, -1, e, bc, ov, gd);
      chk($sformatf("rnd%0d_done %0d/%0d", n, dd, dv), gd, 1);
      chk($sformatf("rnd%0d_quotient %0d/%0d", n, dd, dv), quotient, mq);
      chk($sformatf("rnd%0d_remainder %0d/%0d", n, dd, dv), remainder, mr);
      chk($sformatf("rnd%0d_dbz %0d/%0d", n, dd, dv), div_by_zero, mz);
      chk($sformatf("rnd%0d_latency %0d/%0d", n, dd, dv), e, (dv == 0) ? 1 : 9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Bit-serial unsigned restoring divider that computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. It is the inverse companion of the multiply-accumulate datapath. It reuses a ripple subtractor built from full-adder cells, with the divisor inverted and carry-in tied to 1. The block sits beside the MAC as a start/done slave of the datapath controller.

## Interface
Parameters:
- WIDTH, 8, operand, quotient and remainder width (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- dividend  in  WIDTH  unsigned numerator, captured on the accepting edge
- divisor  in  WIDTH  unsigned denominator, captured on the accepting edge
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; results are valid from this cycle onward
- quotient  out  WIDTH  result quotient; held until the next accepted start
- remainder  out  WIDTH  result remainder; held until the next accepted start
- div_by_zero  out  1  set with done when divisor was 0; held with the results

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 and divisor≠0 → RUN. start=1 and divisor=0 → DONE.
  - RUN: stays for exactly WIDTH cycles (counter WIDTH-1 down to 0), then → DONE.
  - DONE: one cycle. start=1 → RUN or DONE, with the same rules as IDLE. Otherwise → IDLE.
- On accept: R (WIDTH+1 bits) ← 0; Q ← dividend; D ← divisor; div_by_zero ← 0.
- Each RUN cycle performs one step:
  - trial = {R[WIDTH-1:0], Q[WIDTH-1]} − {0, D}, computed by the ripple subtractor.
  - No borrow (trial ≥ 0): R ← trial, Q ← {Q[WIDTH-2:0], 1}.
  - Borrow: R ← {R[WIDTH-1:0], Q[WIDTH-1]}, Q ← {Q[WIDTH-2:0], 0}.
- On entering DONE: quotient ← Q and remainder ← R[WIDTH-1:0].
- Divide-by-zero: quotient ← all ones, remainder ← dividend, div_by_zero ← 1. No RUN cycles.
- start while busy=1 is ignored. Operands are not re-sampled.
- Operands may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE. Internal R, Q, D and counter are also 0.
- Reset asserted mid-RUN aborts immediately (asynchronous). No done pulse is produced. The next start after reset release is accepted normally.
- Normal latency: done=1 in the cycle after the (WIDTH+1)th rising edge counted from the accepting edge. That is WIDTH RUN cycles plus 1 DONE cycle.
- Divide-by-zero latency: done=1 in the cycle after the first edge following acceptance.
- busy rises on the accepting edge and falls on the edge that enters DONE. busy and done are never high together.
- Back-to-back: start=1 during DONE is accepted.
  - done lasts exactly one cycle; busy rises on the next edge.
  - Throughput is one division per WIDTH+1 cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package div_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - default WIDTH.
  - counter width function clog2(WIDTH).
- One sub-module: ripple_sub, (WIDTH+1)-bit.
  - Built as a chain of full-adder cells: b inverted, cin=1.
  - Outputs diff and borrow (borrow = ~carry-out).
- The top level holds the FSM, counter, R/Q/D shift registers and output registers.

## Test plan
All cases use WIDTH=8.
- Reset: assert rst asynchronously between edges → all outputs 0 immediately; state IDLE after release.
- Basic: dividend=100, divisor=7 → done 9 edges after accept; quotient=14, remainder=2, div_by_zero=0; busy high for exactly 8 cycles.
- Boundaries:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
- Divide-by-zero: 200/0 → done 1 edge after accept; quotient=255, remainder=200, div_by_zero=1; busy never high.
- Handshake:
  - start pulsed mid-RUN with different operands → ignored; original result is delivered.
  - start held high through DONE → second division accepted back-to-back; 60/8 yields quotient=7, remainder=4 after a further 9 edges.
- Abort: rst asserted at RUN cycle 4 of 100/7 → no done pulse; outputs 0; a following 9/3 returns quotient=3, remainder=0.
